// File: rtl/fetch_stage.sv
// Instruction fetch stage: registered PC, fetch FSM and IF/ID pipeline register.
// Define FETCH_IMEM_WAIT_EN to honour imem_ready and enable the WAIT state.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        PCsrcD,
    input  logic [31:0] pcBranchD,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pcF,
    output logic        imem_req,
    output logic [31:0] instructionD,
    output logic [31:0] pcplus4D,
    output logic        validD
);

`ifdef FETCH_IMEM_WAIT_EN
    typedef enum logic [1:0] {
        StBoot = 2'd0,
        StRun  = 2'd1,
        StWait = 2'd2
    } fetchState_e;

    logic readyEff;
    logic redirect;

    assign readyEff = imem_ready;
    assign redirect = PCsrcD && !StallF;
`else
    typedef enum logic [1:0] {
        StBoot = 2'd0,
        StRun  = 2'd1
    } fetchState_e;

    logic readyEff;
    logic unusedReady;

    // Memory is treated as always ready in this build.
    assign readyEff    = 1'b1;
    assign unusedReady = imem_ready;
`endif

    fetchState_e state;
    logic [31:0] pcplus4F;
    logic        fetchOk;

    assign pcplus4F = pcF + 32'd4;
    assign fetchOk  = imem_req && readyEff;

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state    <= StBoot;
            imem_req <= 1'b0;
        end else begin
            unique case (state)
                StBoot: begin
                    state    <= StRun;
                    imem_req <= 1'b1;
                end
                StRun: begin
`ifdef FETCH_IMEM_WAIT_EN
                    if (imem_req && !readyEff) begin
                        state <= StWait;
                    end
`endif
                    imem_req <= 1'b1;
                end
`ifdef FETCH_IMEM_WAIT_EN
                StWait: begin
                    // A redirect abandons the pending fetch; the new PC is requested next cycle.
                    if (readyEff || redirect) begin
                        state <= StRun;
                    end
                    imem_req <= 1'b1;
                end
`endif
                default: begin
                    state    <= StBoot;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            pcF <= RESET_PC;
        end else if (StallF) begin
            pcF <= pcF;
        end else if (PCsrcD) begin
            pcF <= pcBranchD;
        end else if (fetchOk) begin
            pcF <= pcplus4F;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            instructionD <= 32'h0000_0000;
            pcplus4D     <= 32'h0000_0000;
            validD       <= 1'b0;
        end else if (StallD) begin
            instructionD <= instructionD;
            pcplus4D     <= pcplus4D;
            validD       <= validD;
        end else if (fetchOk && !StallF && !PCsrcD) begin
            instructionD <= imem_rdata;
            pcplus4D     <= pcplus4F;
            validD       <= 1'b1;
        end else begin
            // Flush on a taken branch, or no word delivered this cycle.
            instructionD <= 32'h0000_0000;
            pcplus4D     <= 32'h0000_0000;
            validD       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: scoreboard of expected IF/ID words against a modelled memory.
module tb_fetch_stage;

    logic        CLK;
    logic        reset;
    logic        StallF;
    logic        StallD;
    logic        PCsrcD;
    logic [31:0] pcBranchD;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] pcF;
    logic        imem_req;
    logic [31:0] instructionD;
    logic [31:0] pcplus4D;
    logic        validD;

    localparam int Bub  = 0;
    localparam int Val  = 1;
    localparam int Hold = 2;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] sb[$];
    logic [31:0] modelPc  = 32'h0;
    logic [31:0] lastInstr = 32'h0;
    logic [31:0] lastP4    = 32'h0;
    logic        lastValid = 1'b0;

    fetch_stage dut (
        .CLK          (CLK),
        .reset        (reset),
        .StallF       (StallF),
        .StallD       (StallD),
        .PCsrcD       (PCsrcD),
        .pcBranchD    (pcBranchD),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .pcF          (pcF),
        .imem_req     (imem_req),
        .instructionD (instructionD),
        .pcplus4D     (pcplus4D),
        .validD       (validD)
    );

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return {addr[15:0] ^ 16'hC3A5, addr[31:16] ^ 16'h5A17} + 32'h1357_9BDF;
    endfunction

    assign imem_rdata = memWord(pcF);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic sf, input logic sd, input logic br,
                        input logic [31:0] tgt, input logic rdy, input logic [31:0] expPc,
                        input logic expReq, input int mode);
        logic [63:0] e;
        @(negedge CLK);
        reset      = rst;
        StallF     = sf;
        StallD     = sd;
        PCsrcD     = br;
        pcBranchD  = tgt;
        imem_ready = rdy;
        if (mode == Val) sb.push_back({memWord(modelPc), modelPc + 32'd4});
        @(posedge CLK);
        #1;
        check32("pcF", pcF, expPc);
        check32("imem_req", 32'(imem_req), 32'(expReq));
        if (mode == Val) begin
            if (sb.size() == 0) begin
                check32("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                lastInstr = e[63:32];
                lastP4    = e[31:0];
                lastValid = 1'b1;
            end
        end else if (mode == Bub) begin
            lastInstr = 32'h0;
            lastP4    = 32'h0;
            lastValid = 1'b0;
        end
        check32("validD", 32'(validD), 32'(lastValid));
        check32("instructionD", instructionD, lastInstr);
        check32("pcplus4D", pcplus4D, lastP4);
        modelPc = expPc;
    endtask

    initial begin
        reset      = 1'b0;
        StallF     = 1'b0;
        StallD     = 1'b0;
        PCsrcD     = 1'b0;
        pcBranchD  = 32'h0;
        imem_ready = 1'b1;

        // Reset, boot cycle with no request, then sequential fetch.
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, Bub);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, Bub);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4, 1'b1, Val);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b1, Val);

        // Taken branch: one bubble, then the target stream.
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h40, 1'b1, Bub);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h44, 1'b1, Val);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h48, 1'b1, Val);

        // Full stall for three cycles, then resume.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h48, 1'b1, Hold);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4C, 1'b1, Val);

        // StallF alone inserts a bubble; StallF outranks a branch on the PC.
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4C, 1'b1, Bub);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h50, 1'b1, Val);
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h300, 1'b1, 32'h50, 1'b1, Bub);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h54, 1'b1, Val);

        // Memory wait at 0x10.
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h10, 1'b1, Bub);
`ifdef FETCH_IMEM_WAIT_EN
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h10, 1'b1, Bub);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h10, 1'b1, Bub);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h14, 1'b1, Val);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h14, 1'b1, Bub);
`else
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h14, 1'b1, Val);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h18, 1'b1, Val);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1C, 1'b1, Val);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h20, 1'b1, Val);
`endif
        // Redirect while the fetch is still outstanding.
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 32'h80, 1'b1, Bub);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h84, 1'b1, Val);

        // PC wrap.
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b1, Bub);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, Val);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4, 1'b1, Val);

        // Reset mid-wait outranks stalls, branch and ready.
`ifdef FETCH_IMEM_WAIT_EN
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h4, 1'b1, Bub);
`else
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h8, 1'b1, Val);
`endif
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, Bub);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, Bub);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4, 1'b1, Val);

        check32("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, the PC value loaded at reset.
REQ-002 SHALL provide port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset  input  1  reset, synchronous and active-low.
REQ-004 SHALL provide port StallF  input  1  from the hazard unit; holds the PC.
REQ-005 SHALL provide port StallD  input  1  from the hazard unit; holds the IF/ID register.
REQ-006 SHALL provide port PCsrcD  input  1  branch taken, resolved in decode.
REQ-007 SHALL provide port pcBranchD  input  32  branch target from decode.
REQ-008 SHALL provide port imem_rdata  input  32  instruction word for pcF.
REQ-009 SHALL provide port imem_ready  input  1  imem_rdata valid this cycle.
REQ-010 SHALL provide port pcF  output  32  fetch address (registered PC).
REQ-011 SHALL provide port imem_req  output  1  fetch request for pcF.
REQ-012 SHALL provide port instructionD  output  32  IF/ID instruction to decode.
REQ-013 SHALL provide port pcplus4D  output  32  IF/ID PC+4 to decode.
REQ-014 SHALL provide port validD  output  1  instructionD is a real instruction, not a bubble.

Function
REQ-015 SHALL compute pcplus4F = pcF + 4 modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-016 SHALL implement the FSM BOOT -> RUN -> WAIT: BOOT for the first cycle after reset with imem_req=0, then unconditionally RUN; RUN -> WAIT when imem_req && !imem_ready; WAIT -> RUN when imem_ready or on redirect.
REQ-017 SHALL drive imem_req=1 in RUN and WAIT and imem_req=0 in BOOT.
REQ-018 SHALL compute fetch_ok = imem_req && imem_ready.
REQ-019 SHALL update the PC with this priority: StallF holds; else PCsrcD loads pcBranchD; else fetch_ok loads pcplus4F; else the PC holds.
REQ-020 SHALL abandon an outstanding WAIT fetch on a redirect (PCsrcD && !StallF), re-request at pcBranchD next cycle, and never deliver the old word.
REQ-021 SHALL update IF/ID with this priority: StallD holds all fields; else PCsrcD loads a bubble (flush); else fetch_ok && !StallF loads imem_rdata, pcplus4F and validD=1; else loads a bubble.
REQ-022 SHALL encode a bubble as instructionD=32'h0000_0000, pcplus4D=32'h0000_0000 and validD=0.
REQ-023 SHALL give a taken branch a one-bubble penalty: the wrong-path word fetched in the PCsrcD cycle never reaches decode.
REQ-024 SHALL give fetch-to-decode latency of exactly one cycle when imem_ready=1.

Reset
REQ-025 SHALL, with reset=0 at a rising CLK edge, set pcF=RESET_PC, FSM=BOOT, instructionD=0, pcplus4D=0 and validD=0.
REQ-026 SHALL give reset priority over StallF, StallD, PCsrcD and imem_ready, including mid-WAIT.

Configuration
REQ-027 SHALL, with macro FETCH_IMEM_WAIT_EN defined, honour imem_ready and implement the WAIT state as specified.
REQ-028 SHALL, without FETCH_IMEM_WAIT_EN, ignore imem_ready, treat it as constant 1, and remove the WAIT state.

Verification
REQ-029 SHALL cover reset release with RESET_PC=0 and imem_ready=1: cycle 1 imem_req=0; then pcF=0,4,8 on successive cycles; validD first 1 with pcplus4D=4.
REQ-030 SHALL cover a branch: PCsrcD=1 with pcBranchD=32'h40 while pcF=8 -> next pcF=32'h40, validD=0 for one cycle, then instructionD=mem[32'h40] and pcplus4D=32'h44.
REQ-031 SHALL cover stalls: StallF=StallD=1 for 3 cycles -> pcF, instructionD and validD unchanged; pipeline resumes at pcF+4 on release.
REQ-032 SHALL cover memory wait: imem_ready=0 for 2 cycles at pcF=32'h10 -> imem_req=1 and pcF held, validD=0 bubbles; on ready, instructionD=mem[32'h10] and pcplus4D=32'h14.
REQ-033 SHALL cover redirect in WAIT: PCsrcD=1 with pcBranchD=32'h80 during WAIT -> old word never shown; next pcF=32'h80.
REQ-034 SHALL cover wrap and mid-operation reset: pcF=32'hFFFF_FFFC -> next pcF=0 and pcplus4D=0; reset=0 mid-WAIT -> pcF=RESET_PC and validD=0 after one edge.
